// File: rtl/flup_stream_checker.sv
// FLUP pass-through checker: two-entry skid buffer, frame FSM, error flags.
// Optional statistics enabled by FLUP_STREAM_CHECKER_STATS_EN.
module flup_stream_checker #(
  parameter int DATA_WIDTH    = 512,
  parameter int SOP_POS_WIDTH = 3,
  parameter int EOP_POS_WIDTH = 6,
  parameter int HDR_WIDTH     = 128,
  parameter int CHANNEL_WIDTH = 4,
  parameter int CNT_WIDTH     = 32,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [DATA_WIDTH-1:0]    RX_DATA,
  input  logic [HDR_WIDTH-1:0]     RX_HEADER,
  input  logic [CHANNEL_WIDTH-1:0] RX_CHANNEL,
  input  logic [SOP_POS_WIDTH-1:0] RX_SOP_POS,
  input  logic [EOP_POS_WIDTH-1:0] RX_EOP_POS,
  input  logic                     RX_SOP,
  input  logic                     RX_EOP,
  input  logic                     RX_SRC_RDY,
  output logic                     RX_DST_RDY,
  output logic [DATA_WIDTH-1:0]    TX_DATA,
  output logic [HDR_WIDTH-1:0]     TX_HEADER,
  output logic [CHANNEL_WIDTH-1:0] TX_CHANNEL,
  output logic [SOP_POS_WIDTH-1:0] TX_SOP_POS,
  output logic [EOP_POS_WIDTH-1:0] TX_EOP_POS,
  output logic                     TX_SOP,
  output logic                     TX_EOP,
  output logic                     TX_SRC_RDY,
  input  logic                     TX_DST_RDY,
  input  logic                     CLEAR,
  output logic [CNT_WIDTH-1:0]     FRAME_CNT,
  output logic [CNT_WIDTH-1:0]     BYTE_CNT,
  output logic [LEN_WIDTH-1:0]     LAST_LEN,
  output logic                     ERR_SOP_IN_FRAME,
  output logic                     ERR_NO_SOP
);

  localparam int SHIFT = EOP_POS_WIDTH - SOP_POS_WIDTH;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    data;
    logic [HDR_WIDTH-1:0]     hdr;
    logic [CHANNEL_WIDTH-1:0] chan;
    logic [SOP_POS_WIDTH-1:0] sop_pos;
    logic [EOP_POS_WIDTH-1:0] eop_pos;
    logic                     sop;
    logic                     eop;
  } word_t;

  typedef enum logic {IDLE, IN_FRAME} state_t;

  word_t      rx_w;
  word_t      head_q;
  word_t      skid_q;
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  logic       rdy_q;
  logic       push;
  logic       pop;
  logic       tx_vld;

  assign rx_w = '{data: RX_DATA, hdr: RX_HEADER,
                  chan: RX_CHANNEL, sop_pos: RX_SOP_POS,
                  eop_pos: RX_EOP_POS, sop: RX_SOP,
                  eop: RX_EOP};

  assign tx_vld = (cnt_q != 2'd0);
  assign push   = RX_SRC_RDY & rdy_q;
  assign pop    = tx_vld & TX_DST_RDY;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)
      cnt_d = cnt_q + 2'd1;
    else if (pop && !push)
      cnt_d = cnt_q - 2'd1;
  end

  // head_q is the visible TX word; skid_q only fills when TX stalls
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      head_q <= '0;
      skid_q <= '0;
      cnt_q  <= 2'd0;
      rdy_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d != 2'd2);
      if (push && (cnt_q == 2'd0 || pop))
        head_q <= rx_w;
      else if (pop && cnt_q == 2'd2)
        head_q <= skid_q;
      if (push && !pop && cnt_q == 2'd1)
        skid_q <= rx_w;
    end
  end

  assign RX_DST_RDY = rdy_q;
  assign TX_SRC_RDY = tx_vld;
  assign TX_DATA    = head_q.data;
  assign TX_HEADER  = head_q.hdr;
  assign TX_CHANNEL = head_q.chan;
  assign TX_SOP_POS = head_q.sop_pos;
  assign TX_EOP_POS = head_q.eop_pos;
  assign TX_SOP     = head_q.sop;
  assign TX_EOP     = head_q.eop;

  logic [EOP_POS_WIDTH-1:0] sb;
  logic w_mid;
  logic w_end;
  logic w_open;
  logic w_cto;
  logic w_whole;

  assign sb      = {RX_SOP_POS, {SHIFT{1'b0}}};
  assign w_mid   = !RX_SOP && !RX_EOP;
  assign w_end   = !RX_SOP && RX_EOP;
  assign w_open  = RX_SOP && !RX_EOP;
  assign w_cto   = RX_SOP && RX_EOP && (sb > RX_EOP_POS);
  assign w_whole = RX_SOP && RX_EOP && (sb <= RX_EOP_POS);

  state_t state_q;
  state_t state_d;
  logic   set_sop_err;
  logic   set_no_sop;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (push) begin
      unique case (state_q)
        IDLE:
          if (w_open || w_cto)
            state_d = IN_FRAME;
        IN_FRAME:
          if (w_end || w_whole)
            state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    set_sop_err = 1'b0;
    set_no_sop  = 1'b0;
    if (push) begin
      unique case (state_q)
        IDLE:
          set_no_sop = w_mid || w_end || w_cto;
        IN_FRAME:
          set_sop_err = w_open || w_whole;
        default: ;
      endcase
    end
  end

  logic err_sif_q;
  logic err_nos_q;

  // a flag raised in the same cycle as CLEAR survives it
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      err_sif_q <= 1'b0;
      err_nos_q <= 1'b0;
    end else begin
      err_sif_q <= (err_sif_q & ~CLEAR) | set_sop_err;
      err_nos_q <= (err_nos_q & ~CLEAR) | set_no_sop;
    end
  end

  assign ERR_SOP_IN_FRAME = err_sif_q;
  assign ERR_NO_SOP       = err_nos_q;

`ifdef FLUP_STREAM_CHECKER_STATS_EN
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LW    = LEN_WIDTH + 1;

  function automatic logic [LEN_WIDTH-1:0] sat(
    input logic [LW-1:0] v
  );
    return v[LEN_WIDTH] ? '1 : v[LEN_WIDTH-1:0];
  endfunction

  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] len_d;
  logic [LEN_WIDTH-1:0] cmp_len;
  logic                 cmpl;
  logic [LW-1:0]        sbx;
  logic [LW-1:0]        eop1;
  logic [LW-1:0]        first;
  logic                 in_f;
  logic [CNT_WIDTH-1:0] frame_q;
  logic [CNT_WIDTH-1:0] byte_q;
  logic [LEN_WIDTH-1:0] last_q;

  assign sbx   = LW'(sb);
  assign eop1  = LW'(RX_EOP_POS) + LW'(1);
  assign first = LW'(BYTES) - sbx;
  assign in_f  = (state_q == IN_FRAME);

  always_comb begin
    len_d   = len_q;
    cmpl    = 1'b0;
    cmp_len = '0;
    if (push) begin
      unique case (1'b1)
        in_f && w_mid:
          len_d = sat(LW'(len_q) + LW'(BYTES));
        in_f && (w_end || w_cto): begin
          cmpl    = 1'b1;
          cmp_len = sat(LW'(len_q) + eop1);
          if (w_cto)
            len_d = sat(first);
        end
        w_whole: begin
          cmpl    = 1'b1;
          cmp_len = sat(eop1 - sbx);
        end
        w_open || (!in_f && w_cto):
          len_d = sat(first);
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      len_q   <= '0;
      frame_q <= '0;
      byte_q  <= '0;
      last_q  <= '0;
    end else begin
      len_q <= len_d;
      if (cmpl)
        last_q <= cmp_len;
      if (CLEAR) begin
        frame_q <= CNT_WIDTH'(cmpl);
        byte_q  <= cmpl ? CNT_WIDTH'(cmp_len) : '0;
      end else if (cmpl) begin
        frame_q <= frame_q + CNT_WIDTH'(1);
        byte_q  <= byte_q + CNT_WIDTH'(cmp_len);
      end
    end
  end

  assign FRAME_CNT = frame_q;
  assign BYTE_CNT  = byte_q;
  assign LAST_LEN  = last_q;
`else
  assign FRAME_CNT = '0;
  assign BYTE_CNT  = '0;
  assign LAST_LEN  = '0;
`endif

endmodule

// File: tb/tb_flup_stream_checker.sv
// Scoreboard bench for flup_stream_checker.
// Expected statistics follow FLUP_STREAM_CHECKER_STATS_EN.
module tb_flup_stream_checker;

`ifdef FLUP_STREAM_CHECKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int DW = 512;

  logic          CLK;
  logic          RESET_N;
  logic [DW-1:0] RX_DATA;
  logic [127:0]  RX_HEADER;
  logic [3:0]    RX_CHANNEL;
  logic [2:0]    RX_SOP_POS;
  logic [5:0]    RX_EOP_POS;
  logic          RX_SOP;
  logic          RX_EOP;
  logic          RX_SRC_RDY;
  logic          RX_DST_RDY;
  logic [DW-1:0] TX_DATA;
  logic [127:0]  TX_HEADER;
  logic [3:0]    TX_CHANNEL;
  logic [2:0]    TX_SOP_POS;
  logic [5:0]    TX_EOP_POS;
  logic          TX_SOP;
  logic          TX_EOP;
  logic          TX_SRC_RDY;
  logic          TX_DST_RDY;
  logic          CLEAR;
  logic [31:0]   FRAME_CNT;
  logic [31:0]   BYTE_CNT;
  logic [15:0]   LAST_LEN;
  logic          ERR_SOP_IN_FRAME;
  logic          ERR_NO_SOP;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [127:0]  hdr;
    logic [3:0]    ch;
    logic [2:0]    sp;
    logic [5:0]    ep;
    logic          sop;
    logic          eop;
  } w_t;

  typedef struct {
    w_t w;
    int cyc;
  } ent_t;

  w_t   rx_w;
  w_t   tx_w;
  ent_t exp_q[$];
  int   tests;
  int   fails;
  int   cyc;
  int   acc_n;
  int   got_n;
  bit   acc;
  bit   chk_lat;

  assign RX_DATA    = rx_w.data;
  assign RX_HEADER  = rx_w.hdr;
  assign RX_CHANNEL = rx_w.ch;
  assign RX_SOP_POS = rx_w.sp;
  assign RX_EOP_POS = rx_w.ep;
  assign RX_SOP     = rx_w.sop;
  assign RX_EOP     = rx_w.eop;
  assign tx_w = '{data: TX_DATA, hdr: TX_HEADER,
                  ch: TX_CHANNEL, sp: TX_SOP_POS,
                  ep: TX_EOP_POS, sop: TX_SOP,
                  eop: TX_EOP};

  flup_stream_checker dut (
    .CLK              (CLK),
    .RESET_N          (RESET_N),
    .RX_DATA          (RX_DATA),
    .RX_HEADER        (RX_HEADER),
    .RX_CHANNEL       (RX_CHANNEL),
    .RX_SOP_POS       (RX_SOP_POS),
    .RX_EOP_POS       (RX_EOP_POS),
    .RX_SOP           (RX_SOP),
    .RX_EOP           (RX_EOP),
    .RX_SRC_RDY       (RX_SRC_RDY),
    .RX_DST_RDY       (RX_DST_RDY),
    .TX_DATA          (TX_DATA),
    .TX_HEADER        (TX_HEADER),
    .TX_CHANNEL       (TX_CHANNEL),
    .TX_SOP_POS       (TX_SOP_POS),
    .TX_EOP_POS       (TX_EOP_POS),
    .TX_SOP           (TX_SOP),
    .TX_EOP           (TX_EOP),
    .TX_SRC_RDY       (TX_SRC_RDY),
    .TX_DST_RDY       (TX_DST_RDY),
    .CLEAR            (CLEAR),
    .FRAME_CNT        (FRAME_CNT),
    .BYTE_CNT         (BYTE_CNT),
    .LAST_LEN         (LAST_LEN),
    .ERR_SOP_IN_FRAME (ERR_SOP_IN_FRAME),
    .ERR_NO_SOP       (ERR_NO_SOP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] ex(input int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  function automatic w_t mk(input bit s, input bit e,
                            input int sp, input int ep);
    w_t w;
    for (int i = 0; i < DW / 32; i++)
      w.data[i*32 +: 32] = $urandom();
    for (int i = 0; i < 4; i++)
      w.hdr[i*32 +: 32] = $urandom();
    w.ch  = 4'($urandom_range(0, 15));
    w.sp  = 3'(sp);
    w.ep  = 6'(ep);
    w.sop = s;
    w.eop = e;
    return w;
  endfunction

  // one cycle: pop/compare TX output, push accepted RX words
  task automatic tick();
    ent_t e;
    @(negedge CLK);
    acc = RX_SRC_RDY && RX_DST_RDY;
    if (TX_SRC_RDY && TX_DST_RDY) begin
      got_n++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_extra: got %h want no word", tx_w);
      end else begin
        e = exp_q.pop_front();
        if (tx_w !== e.w) begin
          fails++;
          $display("FAIL sb_word: got %h want %h", tx_w, e.w);
        end
        if (chk_lat) begin
          tests++;
          if (cyc - e.cyc !== 1) begin
            fails++;
            $display("FAIL sb_latency: got %0d want 1",
                     cyc - e.cyc);
          end
        end
      end
    end
    if (acc) begin
      exp_q.push_back('{w: rx_w, cyc: cyc});
      acc_n++;
    end
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input w_t w);
    rx_w = w;
    RX_SRC_RDY = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (acc) break;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got no accept want accept");
    end
  endtask

  task automatic idle(input int n);
    RX_SRC_RDY = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_clear();
    RX_SRC_RDY = 1'b0;
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    #1;
    tests++;
    if ({TX_SRC_RDY, RX_DST_RDY, TX_SOP, TX_EOP} !== 4'b0) begin
      fails++;
      $display("FAIL rst_ctrl: got %b want 0000",
               {TX_SRC_RDY, RX_DST_RDY, TX_SOP, TX_EOP});
    end
    tests++;
    if (TX_DATA !== '0 || TX_HEADER !== '0) begin
      fails++;
      $display("FAIL rst_data: got %h want 0", TX_DATA[63:0]);
    end
    tests++;
    if ({FRAME_CNT, BYTE_CNT, LAST_LEN} !== '0 ||
        {ERR_SOP_IN_FRAME, ERR_NO_SOP} !== 2'b0) begin
      fails++;
      $display("FAIL rst_stats: got %0d/%0d/%0d want 0",
               FRAME_CNT, BYTE_CNT, LAST_LEN);
    end
    RESET_N = 1'b1;
    tick();
    tests++;
    if (RX_DST_RDY !== 1'b1) begin
      fails++;
      $display("FAIL rst_rdy: got %b want 1", RX_DST_RDY);
    end
  endtask

  task automatic test_single();
    send(mk(1, 1, 1, 63));
    RX_SRC_RDY = 1'b0;
    tests++;
    if (LAST_LEN !== ex(56)) begin
      fails++;
      $display("FAIL single_len: got %0d want %0d",
               LAST_LEN, ex(56));
    end
    tests++;
    if (FRAME_CNT !== ex(1) || BYTE_CNT !== ex(56)) begin
      fails++;
      $display("FAIL single_cnt: got %0d/%0d want %0d/%0d",
               FRAME_CNT, BYTE_CNT, ex(1), ex(56));
    end
    tests++;
    if ({ERR_SOP_IN_FRAME, ERR_NO_SOP} !== 2'b0) begin
      fails++;
      $display("FAIL single_err: got %b want 00",
               {ERR_SOP_IN_FRAME, ERR_NO_SOP});
    end
    send(mk(1, 1, 0, 0));
    RX_SRC_RDY = 1'b0;
    tests++;
    if (LAST_LEN !== ex(1) || FRAME_CNT !== ex(2) ||
        BYTE_CNT !== ex(57)) begin
      fails++;
      $display("FAIL single_min: got %0d/%0d/%0d want %0d/%0d/%0d",
               LAST_LEN, FRAME_CNT, BYTE_CNT, ex(1), ex(2), ex(57));
    end
    idle(3);
  endtask

  task automatic test_three();
    do_clear();
    chk_lat = 1'b1;
    send(mk(1, 0, 0, 0));
    send(mk(0, 0, 0, 0));
    send(mk(0, 1, 0, 9));
    RX_SRC_RDY = 1'b0;
    tests++;
    if (LAST_LEN !== ex(138) || FRAME_CNT !== ex(1)) begin
      fails++;
      $display("FAIL three_len: got %0d/%0d want %0d/%0d",
               LAST_LEN, FRAME_CNT, ex(138), ex(1));
    end
    idle(3);
    chk_lat = 1'b0;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL three_drain: got %0d left want 0",
               exp_q.size());
    end
  endtask

  task automatic test_cto();
    do_clear();
    send(mk(1, 0, 0, 0));
    send(mk(1, 1, 4, 15));
    RX_SRC_RDY = 1'b0;
    tests++;
    if (LAST_LEN !== ex(80) || FRAME_CNT !== ex(1) ||
        BYTE_CNT !== ex(80)) begin
      fails++;
      $display("FAIL cto_close: got %0d/%0d/%0d want %0d/%0d/%0d",
               LAST_LEN, FRAME_CNT, BYTE_CNT, ex(80), ex(1), ex(80));
    end
    send(mk(0, 1, 0, 63));
    RX_SRC_RDY = 1'b0;
    tests++;
    if (LAST_LEN !== ex(96) || FRAME_CNT !== ex(2) ||
        BYTE_CNT !== ex(176)) begin
      fails++;
      $display("FAIL cto_open: got %0d/%0d/%0d want %0d/%0d/%0d",
               LAST_LEN, FRAME_CNT, BYTE_CNT, ex(96), ex(2), ex(176));
    end
    tests++;
    if ({ERR_SOP_IN_FRAME, ERR_NO_SOP} !== 2'b0) begin
      fails++;
      $display("FAIL cto_err: got %b want 00",
               {ERR_SOP_IN_FRAME, ERR_NO_SOP});
    end
    idle(3);
  endtask

  task automatic test_sop_in_frame();
    do_clear();
    send(mk(1, 0, 0, 0));
    send(mk(1, 0, 0, 0));
    RX_SRC_RDY = 1'b0;
    tests++;
    if (ERR_SOP_IN_FRAME !== 1'b1 || ERR_NO_SOP !== 1'b0) begin
      fails++;
      $display("FAIL sif_flag: got %b want 10",
               {ERR_SOP_IN_FRAME, ERR_NO_SOP});
    end
    tests++;
    if (FRAME_CNT !== 32'd0) begin
      fails++;
      $display("FAIL sif_cnt0: got %0d want 0", FRAME_CNT);
    end
    send(mk(0, 1, 0, 63));
    RX_SRC_RDY = 1'b0;
    tests++;
    if (FRAME_CNT !== ex(1) || LAST_LEN !== ex(128)) begin
      fails++;
      $display("FAIL sif_close: got %0d/%0d want %0d/%0d",
               FRAME_CNT, LAST_LEN, ex(1), ex(128));
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    w_t ws[12];
    w_t hold;
    int i;
    int acc_stall;
    do_clear();
    for (int k = 0; k < 12; k++)
      ws[k] = mk(k == 0, k == 11, 0, 63);
    i = 0;
    acc_n = 0;
    got_n = 0;
    acc_stall = 0;
    hold = '0;
    for (int c = 0; c < 40; c++) begin
      if (i < 12) begin
        rx_w = ws[i];
        RX_SRC_RDY = 1'b1;
      end else begin
        RX_SRC_RDY = 1'b0;
      end
      TX_DST_RDY = !(c >= 3 && c < 8);
      tick();
      if (acc) i++;
      if (c == 3) begin
        hold = tx_w;
        acc_stall = acc_n;
        tests++;
        if (RX_DST_RDY !== 1'b0) begin
          fails++;
          $display("FAIL bp_rdy_low: got %b want 0", RX_DST_RDY);
        end
      end
      if (c == 7) begin
        tests++;
        if (tx_w !== hold) begin
          fails++;
          $display("FAIL bp_hold: got %h want %h",
                   tx_w.data[63:0], hold.data[63:0]);
        end
        tests++;
        if (acc_n - got_n !== 2) begin
          fails++;
          $display("FAIL bp_buffered: got %0d want 2",
                   acc_n - got_n);
        end
        tests++;
        if (acc_n !== acc_stall) begin
          fails++;
          $display("FAIL bp_extra: got %0d want %0d",
                   acc_n, acc_stall);
        end
      end
    end
    RX_SRC_RDY = 1'b0;
    TX_DST_RDY = 1'b1;
    tests++;
    if (i !== 12 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL bp_drain: got %0d sent %0d left want 12 0",
               i, exp_q.size());
    end
    tests++;
    if (LAST_LEN !== ex(768) || FRAME_CNT !== ex(1)) begin
      fails++;
      $display("FAIL bp_len: got %0d/%0d want %0d/%0d",
               LAST_LEN, FRAME_CNT, ex(768), ex(1));
    end
  endtask

  task automatic test_clear_win();
    do_clear();
    send(mk(1, 1, 1, 63));
    send(mk(0, 0, 0, 0));
    RX_SRC_RDY = 1'b0;
    tests++;
    if (ERR_NO_SOP !== 1'b1) begin
      fails++;
      $display("FAIL clr_pre: got %b want 1", ERR_NO_SOP);
    end
    CLEAR = 1'b1;
    send(mk(1, 1, 2, 31));
    CLEAR = 1'b0;
    RX_SRC_RDY = 1'b0;
    tests++;
    if (FRAME_CNT !== ex(1) || BYTE_CNT !== ex(16) ||
        LAST_LEN !== ex(16)) begin
      fails++;
      $display("FAIL clr_win: got %0d/%0d/%0d want %0d/%0d/%0d",
               FRAME_CNT, BYTE_CNT, LAST_LEN, ex(1), ex(16), ex(16));
    end
    tests++;
    if (ERR_NO_SOP !== 1'b0) begin
      fails++;
      $display("FAIL clr_flag: got %b want 0", ERR_NO_SOP);
    end
    idle(3);
  endtask

  task automatic test_reset_mid();
    do_clear();
    TX_DST_RDY = 1'b0;
    send(mk(1, 0, 0, 0));
    send(mk(0, 0, 0, 0));
    RX_SRC_RDY = 1'b0;
    RESET_N = 1'b0;
    #1;
    tests++;
    if (TX_SRC_RDY !== 1'b0 || RX_DST_RDY !== 1'b0 ||
        TX_DATA !== '0) begin
      fails++;
      $display("FAIL rmid_out: got %b%b want 00",
               TX_SRC_RDY, RX_DST_RDY);
    end
    exp_q.delete();
    tick();
    RESET_N = 1'b1;
    TX_DST_RDY = 1'b1;
    tick();
    send(mk(0, 0, 0, 0));
    RX_SRC_RDY = 1'b0;
    tests++;
    if (ERR_NO_SOP !== 1'b1 || ERR_SOP_IN_FRAME !== 1'b0) begin
      fails++;
      $display("FAIL rmid_flag: got %b want 01",
               {ERR_SOP_IN_FRAME, ERR_NO_SOP});
    end
    tests++;
    if (FRAME_CNT !== 32'd0) begin
      fails++;
      $display("FAIL rmid_cnt: got %0d want 0", FRAME_CNT);
    end
    idle(3);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL rmid_drain: got %0d left want 0",
               exp_q.size());
    end
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    cyc        = 0;
    acc_n      = 0;
    got_n      = 0;
    acc        = 1'b0;
    chk_lat    = 1'b0;
    RESET_N    = 1'b0;
    CLEAR      = 1'b0;
    RX_SRC_RDY = 1'b0;
    TX_DST_RDY = 1'b1;
    rx_w       = '0;
    test_reset();
    test_single();
    test_three();
    test_cto();
    test_sop_in_frame();
    test_back_to_back();
    test_clear_win();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/flup_stream_checker.md
# flup_stream_checker

Pass-through FrameLink Unaligned Plus (FLUP) stage placed directly in front of any FLUP consumer. It registers the stream through a two-entry skid buffer at full throughput, tracks frame boundaries, checks protocol and accumulates frame and byte statistics. The data path is never modified: every accepted word is forwarded unchanged and in order.

## Interface
- DATA_WIDTH, 512, data bus width; BYTES = DATA_WIDTH/8
- SOP_POS_WIDTH, 3, SOP pointer width; SOP unit U = 2**(EOP_POS_WIDTH-SOP_POS_WIDTH) bytes
- EOP_POS_WIDTH, 6, EOP byte pointer width, log2(BYTES)
- HDR_WIDTH, 128, header width
- CHANNEL_WIDTH, 4, channel width
- CNT_WIDTH, 32, statistics counter width
- LEN_WIDTH, 16, frame length register width

- CLK  in  1  clock; single clock domain
- RESET_N  in  1  asynchronous active-low reset
- RX_DATA, RX_HEADER, RX_CHANNEL, RX_SOP_POS, RX_EOP_POS, RX_SOP, RX_EOP  in  per params  FLUP input word
- RX_SRC_RDY  in  1;  RX_DST_RDY  out  1
- TX_DATA, TX_HEADER, TX_CHANNEL, TX_SOP_POS, TX_EOP_POS, TX_SOP, TX_EOP  out  per params  FLUP output word
- TX_SRC_RDY  out  1;  TX_DST_RDY  in  1
- CLEAR  in  1  synchronous clear of counters and error flags
- FRAME_CNT  out  CNT_WIDTH  completed frames
- BYTE_CNT  out  CNT_WIDTH  bytes in completed frames
- LAST_LEN  out  LEN_WIDTH  length of last completed frame
- ERR_SOP_IN_FRAME  out  1  sticky: SOP while frame open
- ERR_NO_SOP  out  1  sticky: transfer outside frame without SOP

## Operation
- Transfer = RX_SRC_RDY && RX_DST_RDY. sb = RX_SOP_POS*U. Word closes-then-opens when SOP && EOP && sb > EOP_POS; word holds whole frame when SOP && EOP && sb <= EOP_POS.
- FSM IDLE / IN_FRAME, evaluated only on transfer:
  - IDLE, whole frame: complete with len EOP_POS+1-sb; stay IDLE.
  - IDLE, SOP (no EOP or close-then-open): len := BYTES-sb; go IN_FRAME. Close-then-open in IDLE additionally sets ERR_NO_SOP (orphan EOP part ignored).
  - IDLE, no SOP: set ERR_NO_SOP; word ignored for stats; stay IDLE.
  - IN_FRAME, no SOP, no EOP: len += BYTES.
  - IN_FRAME, EOP without SOP: complete with len+EOP_POS+1; go IDLE.
  - IN_FRAME, close-then-open: complete with len+EOP_POS+1; new len := BYTES-sb; stay IN_FRAME.
  - IN_FRAME, SOP without EOP or whole frame: set ERR_SOP_IN_FRAME; open frame abandoned (not counted); word treated as in IDLE.
- Completion: FRAME_CNT += 1, BYTE_CNT += len, LAST_LEN := len. Counters wrap modulo 2**CNT_WIDTH; len saturates at 2**LEN_WIDTH-1.
- CLEAR zeroes counters and error flags; a completion in the same cycle wins over clear for its own contribution (FRAME_CNT=1, BYTE_CNT=len). CLEAR does not affect FSM or data path.
- Skid buffer: two entries; forwards words in order, no drop, no duplication.

## Timing
- Reset: TX_SRC_RDY=0, all TX_* data/control=0, RX_DST_RDY=0 while RESET_N low, 1 in first cycle after release; counters, LAST_LEN, flags 0; FSM IDLE; buffer empty.
- RX→TX latency 1 cycle when buffer empty and TX_DST_RDY=1; throughput one word per cycle.
- RX_DST_RDY registered: low only when buffer holds two words; at most one extra word accepted after TX_DST_RDY falls.
- TX word held stable while TX_SRC_RDY=1 and TX_DST_RDY=0.
- Statistics and flags visible the cycle after the RX transfer edge.
- RESET_N asserted mid-frame: open frame discarded, buffered words lost, all outputs to reset values immediately.

## Configuration
- FLUP_STREAM_CHECKER_STATS_EN: defined → FRAME_CNT, BYTE_CNT, LAST_LEN implemented as above. Undefined → length/counter logic removed, these outputs constant 0; FSM, error flags and data path unchanged.

## Test plan
- 512-bit, single word SOP_POS=1, EOP_POS=63 → LAST_LEN=56, FRAME_CNT=1, BYTE_CNT=56, no errors.
- Three words SOP_POS=0, middle, EOP_POS=9 → LAST_LEN=138, FRAME_CNT=1; TX sequence identical, latency 1.
- Open frame (len 64), next word SOP_POS=4, EOP_POS=15 → completes len 80; new frame starts with 32; FSM IN_FRAME.
- SOP word, then SOP word without EOP → ERR_SOP_IN_FRAME=1, FRAME_CNT unchanged; following EOP_POS=63 word → FRAME_CNT=1, LAST_LEN=128.
- Continuous RX, TX_DST_RDY low 5 cycles → RX_DST_RDY low within 2 cycles, exactly 2 words buffered, all words delivered in order after release.
- RESET_N low mid-frame, then middle word without SOP → all outputs reset values; after release ERR_NO_SOP=1, FRAME_CNT=0.
